bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning parallel word width in bits, legal range 1..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = transmit bit W-1 first and 0 = transmit bit 0 first.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-005 The block SHALL have port din, input, W bits, meaning parallel word to serialize.
REQ-006 The block SHALL have port din_valid, input, 1 bit, meaning din holds a word to send.
REQ-007 The block SHALL have port din_ready, output, 1 bit, meaning the block accepts din this cycle.
REQ-008 The block SHALL have port bit_out, output, 1 bit, meaning the current serial bit fed to the downstream sequence detector.
REQ-009 The block SHALL have port bit_valid, output, 1 bit, meaning bit_out is meaningful this cycle.
REQ-010 The block SHALL have port bit_ready, input, 1 bit, meaning the downstream consumes bit_out this cycle.
REQ-011 The block SHALL have port last, output, 1 bit, meaning bit_out is the final bit of the current word.
REQ-012 The block SHALL have port words_sent, output, 16 bits, meaning count of fully transmitted words, saturating.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE (no word held) and SHIFT (word held, bits pending).
REQ-014 The block SHALL define a word accept as din_valid && din_ready at a rising edge; a bit transfer as bit_valid && bit_ready at a rising edge.
REQ-015 The block SHALL drive din_ready = 1 in IDLE, and in SHIFT only when last && bit_ready (same-cycle refill); din_ready is combinational and independent of din_valid.
REQ-016 The block SHALL, on word accept, load din into the shift register, clear the bit index to 0, and enter or stay in SHIFT.
REQ-017 The block SHALL drive bit_valid = 1 exactly when in SHIFT; the first bit of an accepted word appears the cycle after acceptance (latency 1).
REQ-018 The block SHALL drive bit_out from shreg[W-1] when MSB_FIRST=1, else from shreg[0]; bit_out is 0 in IDLE.
REQ-019 The block SHALL, on a non-final bit transfer, shift the register one position toward the output end (zero fill) and increment the bit index.
REQ-020 The block SHALL hold bit_out, last and the bit index stable while bit_valid && !bit_ready (stall, any length).
REQ-021 The block SHALL assert last when in SHIFT and bit index == W-1; for W=1 last equals bit_valid.
REQ-022 The block SHALL, on the final bit transfer with no simultaneous word accept, return to IDLE; with a simultaneous accept, stay in SHIFT and present the new word's first bit next cycle (no bubble).
REQ-023 The block SHALL increment words_sent on each final bit transfer, saturating at 16'hFFFF.
REQ-024 The block SHALL ignore din and din_valid when din_ready = 0; no word is lost or duplicated.
REQ-025 The bit index register SHALL be max(1, clog2(W)) bits wide.

Reset
REQ-026 The block SHALL, while rst = 1 at a rising edge, enter IDLE, clear shift register, bit index and words_sent to 0.
REQ-027 The block SHALL hold din_ready = 0 while rst is high; after reset bit_valid = 0, bit_out = 0, last = 0, words_sent = 0.
REQ-028 The block SHALL discard a partially sent word on reset mid-operation, without incrementing words_sent.

Verification
REQ-029 W=8, MSB_FIRST=1, bit_ready=1, accept din=8'b0110_1110 -> bit_out 0,1,1,0,1,1,1,0 on cycles 1..8 after accept, last only on cycle 8, words_sent=1.
REQ-030 MSB_FIRST=0, same din -> bit_out 0,1,1,1,0,1,1,0; din_ready=0 during cycles 1..7 while bit_ready=1.
REQ-031 Two words 8'hFF then 8'h00 with din_valid held -> 16 consecutive bit_valid cycles, no gap, words_sent=2.
REQ-032 bit_ready=0 for 5 cycles during bit index 3 of 8'hA5 -> bit_out, last, index frozen; resume completes remaining bits unchanged.
REQ-033 rst pulsed after 4 bits of 8'hC3 -> next cycle bit_valid=0, din_ready=1 after rst falls, words_sent unchanged.
REQ-034 W=1, din=1'b1 repeatedly with bit_ready=1 -> bit_valid and last high every cycle, words_sent increments every cycle.

Source files
------------

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer
//  Description : Parallel-to-serial converter with valid/ready on both sides,
//                same-cycle refill on the final bit and a saturating word count.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         bit_out,
    output logic         bit_valid,
    input  logic         bit_ready,
    output logic         last,
    output logic [15:0]  words_sent
);

    localparam int              c_IW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(W - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_shreg, w_shreg_nxt, w_shifted;
    logic [c_IW-1:0] r_idx, w_idx_nxt;
    logic [15:0]     r_words, w_words_nxt;
    logic            w_head, w_shift, w_accept, w_xfer;

    // The output end of the register and the shift direction follow bit order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head    = r_shreg[W-1];
            assign w_shifted = r_shreg << 1;
        end else begin : g_lsb_first
            assign w_head    = r_shreg[0];
            assign w_shifted = r_shreg >> 1;
        end
    endgenerate

    assign w_shift    = (r_state == S_SHIFT);
    assign bit_valid  = w_shift;
    assign bit_out    = w_shift & w_head;
    assign last       = w_shift && (r_idx == c_LAST_IDX);
    assign din_ready  = !rst && (!w_shift || (last && bit_ready));
    assign words_sent = r_words;
    assign w_accept   = din_valid && din_ready;
    assign w_xfer     = bit_valid && bit_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_idx_nxt   = r_idx;
        w_words_nxt = r_words;
        if (w_accept) begin
            w_state_nxt = S_SHIFT;
            w_shreg_nxt = din;
            w_idx_nxt   = '0;
        end else if (w_xfer) begin
            if (last) begin
                w_state_nxt = S_IDLE;
                w_shreg_nxt = '0;
                w_idx_nxt   = '0;
            end else begin
                w_shreg_nxt = w_shifted;
                w_idx_nxt   = r_idx + c_IW'(1);
            end
        end
        // A refill on the final bit still completes the outgoing word.
        if (w_xfer && last && (r_words != 16'hFFFF)) begin
            w_words_nxt = r_words + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_words <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_idx   <= w_idx_nxt;
            r_words <= w_words_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serializer
//  Description : Self-checking bench for bit_serializer (W=8 MSB/LSB, W=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  dn  [3];
    logic        dv  [3];
    logic        br  [3];
    logic        dr  [3];
    logic        bo  [3];
    logic        bvl [3];
    logic        lst [3];
    logic [15:0] ws  [3];

    int n_checks = 0;
    int n_fail   = 0;
    int wd  [3] = '{8, 8, 1};
    int msb [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    bit_serializer #(.W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(dn[0]), .din_valid(dv[0]), .din_ready(dr[0]),
        .bit_out(bo[0]), .bit_valid(bvl[0]), .bit_ready(br[0]), .last(lst[0]),
        .words_sent(ws[0]));

    bit_serializer #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(dn[1]), .din_valid(dv[1]), .din_ready(dr[1]),
        .bit_out(bo[1]), .bit_valid(bvl[1]), .bit_ready(br[1]), .last(lst[1]),
        .words_sent(ws[1]));

    bit_serializer #(.W(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .din(dn[2][0:0]), .din_valid(dv[2]), .din_ready(dr[2]),
        .bit_out(bo[2]), .bit_valid(bvl[2]), .bit_ready(br[2]), .last(lst[2]),
        .words_sent(ws[2]));

    typedef struct {
        logic       dv;
        logic [7:0] din;
        logic       br;
        logic       e_dr;
        logic       e_bv;
        logic       e_bo;
        logic       e_last;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        for (int s = 0; s < 3; s++) begin
            dn[s] = '0; dv[s] = 1'b0; br[s] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_din_ready[%0d]", s), 32'(dr[s]), 32'd0);
            chk($sformatf("rst_bit_valid[%0d]", s), 32'(bvl[s]), 32'd0);
            chk($sformatf("rst_bit_out[%0d]", s), 32'(bo[s]), 32'd0);
            chk($sformatf("rst_last[%0d]", s), 32'(lst[s]), 32'd0);
            chk($sformatf("rst_words[%0d]", s), 32'(ws[s]), 32'd0);
        end
        rst = 1'b0;
    endtask

    task automatic fill_table(input int b0, b1, b2, b3, b4, b5, b6, b7);
        int bits [8];
        bits = '{b0, b1, b2, b3, b4, b5, b6, b7};
        tbl[0] = '{1'b1, 8'h6E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 1; k <= 8; k++)
            tbl[k] = '{1'b0, 8'h00, 1'b1, (k == 8), 1'b1, bits[k-1][0], (k == 8)};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    endtask

    task automatic run_table(input int s, input string tag);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dv[s] = tbl[i].dv; dn[s] = tbl[i].din; br[s] = tbl[i].br;
            #1;
            chk($sformatf("%s[%0d].din_ready", tag, i), 32'(dr[s]), 32'(tbl[i].e_dr));
            chk($sformatf("%s[%0d].bit_valid", tag, i), 32'(bvl[s]), 32'(tbl[i].e_bv));
            chk($sformatf("%s[%0d].bit_out", tag, i), 32'(bo[s]), 32'(tbl[i].e_bo));
            chk($sformatf("%s[%0d].last", tag, i), 32'(lst[s]), 32'(tbl[i].e_last));
        end
        chk($sformatf("%s.words_sent", tag), 32'(ws[s]), 32'd1);
    endtask

    // Reference model: the bits still owed downstream, in transmit order.
    task automatic run_random(input int s, input int ncyc);
        bit mq[$];
        int mwords = 0;
        logic e_dr, e_bv, e_bo, e_last, acc, xf;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            dv[s] = ($urandom_range(0, 3) != 0);
            br[s] = ($urandom_range(0, 3) != 0);
            dn[s] = 8'($urandom);
            #1;
            e_bv   = (mq.size() > 0);
            e_bo   = e_bv ? mq[0] : 1'b0;
            e_last = (mq.size() == 1);
            e_dr   = (mq.size() == 0) || (e_last && br[s]);
            chk($sformatf("rnd%0d.din_ready", s), 32'(dr[s]), 32'(e_dr));
            chk($sformatf("rnd%0d.bit_valid", s), 32'(bvl[s]), 32'(e_bv));
            chk($sformatf("rnd%0d.bit_out", s), 32'(bo[s]), 32'(e_bo));
            chk($sformatf("rnd%0d.last", s), 32'(lst[s]), 32'(e_last));
            chk($sformatf("rnd%0d.words", s), 32'(ws[s]), 32'(mwords));
            acc = dv[s] && e_dr;
            xf  = e_bv && br[s];
            @(posedge clk);
            if (xf) begin
                if (mq.size() == 1 && mwords < 65535) mwords++;
                void'(mq.pop_front());
            end
            if (acc)
                for (int i = 0; i < wd[s]; i++)
                    mq.push_back(dn[s][(msb[s] != 0) ? (wd[s] - 1 - i) : i]);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        do_reset();

        fill_table(0, 1, 1, 0, 1, 1, 1, 0);
        run_table(0, "msb6E");
        do_reset();
        fill_table(0, 1, 1, 1, 0, 1, 1, 0);
        run_table(1, "lsb6E");

        // Back-to-back words FF then 00 with din_valid held: no bubble.
        begin
            int accepts = 0;
            do_reset();
            for (int c = 0; c < 19; c++) begin
                @(negedge clk);
                dn[0] = (accepts == 0) ? 8'hFF : 8'h00;
                dv[0] = (accepts < 2);
                br[0] = 1'b1;
                #1;
                if (c >= 1 && c <= 16) begin
                    chk($sformatf("b2b[%0d].bit_valid", c), 32'(bvl[0]), 32'd1);
                    chk($sformatf("b2b[%0d].bit_out", c), 32'(bo[0]), 32'(c <= 8));
                end else if (c == 17) begin
                    chk("b2b.gap_after", 32'(bvl[0]), 32'd0);
                end
                if (dv[0] && dr[0]) accepts++;
            end
            chk("b2b.words_sent", 32'(ws[0]), 32'd2);
            idle_inputs();
        end

        // Five-cycle stall at bit index 3 of A5.
        begin
            int k = 0;
            int stall = 0;
            logic [7:0] w = 8'hA5;
            do_reset();
            @(negedge clk);
            dn[0] = w; dv[0] = 1'b1; br[0] = 1'b1;
            for (int c = 0; c < 20 && k < 8; c++) begin
                @(negedge clk);
                dv[0] = 1'b0;
                br[0] = (k == 3 && stall < 5) ? 1'b0 : 1'b1;
                #1;
                chk($sformatf("stall[%0d].bit_valid", c), 32'(bvl[0]), 32'd1);
                chk($sformatf("stall[%0d].bit_out", c), 32'(bo[0]), 32'(w[7-k]));
                chk($sformatf("stall[%0d].last", c), 32'(lst[0]), 32'(k == 7));
                if (br[0]) k++; else stall++;
            end
            chk("stall.bits_done", 32'(k), 32'd8);
            chk("stall.cycles", 32'(stall), 32'd5);
            @(negedge clk);
            br[0] = 1'b0;
            #1;
            chk("stall.words_sent", 32'(ws[0]), 32'd1);
            chk("stall.idle_after", 32'(bvl[0]), 32'd0);
        end

        // Reset after four bits of C3 discards the word.
        begin
            logic [7:0] w = 8'hC3;
            do_reset();
            @(negedge clk);
            dn[0] = w; dv[0] = 1'b1; br[0] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                dv[0] = 1'b0;
                #1;
                chk($sformatf("mid[%0d].bit_out", k), 32'(bo[0]), 32'(w[7-k]));
            end
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("mid.din_ready_in_rst", 32'(dr[0]), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("mid.bit_valid", 32'(bvl[0]), 32'd0);
            chk("mid.bit_out", 32'(bo[0]), 32'd0);
            chk("mid.last", 32'(lst[0]), 32'd0);
            chk("mid.din_ready", 32'(dr[0]), 32'd1);
            chk("mid.words_sent", 32'(ws[0]), 32'd0);
            idle_inputs();
        end

        // W=1: a word every cycle.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            dn[2] = 8'h01; dv[2] = 1'b1; br[2] = 1'b1;
            #1;
            chk($sformatf("w1[%0d].din_ready", c), 32'(dr[2]), 32'd1);
            if (c == 0) begin
                chk("w1[0].bit_valid", 32'(bvl[2]), 32'd0);
            end else begin
                chk($sformatf("w1[%0d].bit_valid", c), 32'(bvl[2]), 32'd1);
                chk($sformatf("w1[%0d].last", c), 32'(lst[2]), 32'd1);
                chk($sformatf("w1[%0d].bit_out", c), 32'(bo[2]), 32'd1);
                chk($sformatf("w1[%0d].words", c), 32'(ws[2]), 32'(c - 1));
            end
        end
        idle_inputs();

        run_random(0, 600);
        run_random(1, 600);
        run_random(2, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
